// File: rtl/pico_sim.sv
// pico_sim: host-side front end of the Smith-Waterman accelerator.
// It holds the scoring registers written over PicoBus, deframes two-beat
// inbound packets into engine jobs, and queues engine results as
// outbound stream beats.
module pico_sim #(
  parameter int OUT_FIFO_DEPTH = 4,
  parameter int NUM_REGS       = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [31:0]  PicoAddr,
  input  logic [31:0]  PicoDataIn,
  input  logic         PicoWr,
  input  logic         PicoRd,
  output logic [31:0]  PicoDataOut,
  input  logic         si_valid,
  input  logic [127:0] si_data,
  output logic         si_rdy,
  output logic         so_valid,
  output logic [127:0] so_data,
  input  logic         so_rdy,
  output logic [383:0] score_params,
  output logic         job_valid,
  input  logic         job_ready,
  output logic [127:0] job_query,
  output logic [15:0]  job_id,
  output logic [31:0]  job_ref_addr,
  output logic [31:0]  job_query_len,
  output logic [31:0]  job_ref_len,
  input  logic         res_valid,
  output logic         res_ready,
  input  logic [15:0]  res_query_id,
  input  logic [31:0]  res_loc
);

  localparam int AW = $clog2(OUT_FIFO_DEPTH);
  localparam logic [31:0] STATUS_ADDR = 32'h0000_0030;

  typedef enum logic [1:0] {HDR = 2'd0, QUERY = 2'd1, ISSUE = 2'd2} state_t;

  state_t        state_r, state_next_s;
  logic [31:0]   regs_r [NUM_REGS];
  logic [31:0]   rdata_r, rd_mux_s;
  logic          si_rdy_r, res_ready_r;
  logic [127:0]  query_r;
  logic [15:0]   id_r;
  logic [31:0]   ref_addr_r, query_len_r, ref_len_r;
  logic [127:0]  mem_r [OUT_FIFO_DEPTH];
  logic [AW:0]   wptr_r, rptr_r, count_r, count_next_s;
  logic          wr_hit_s, push_s, pop_s, si_xfer_s;

  // Flatten the scoring registers onto the parameter bus.
  for (genvar k = 0; k < NUM_REGS; k++) begin : g_params
    assign score_params[32*k +: 32] = regs_r[k];
  end

  assign wr_hit_s  = PicoWr && (PicoAddr[1:0] == 2'b00) && (PicoAddr < 32'(NUM_REGS * 4));
  assign si_xfer_s = si_valid && si_rdy_r;
  assign push_s    = res_valid && res_ready_r;
  assign pop_s     = so_valid && so_rdy;

  // Scoring register file; writes land on the next edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_r[i] <= 32'h0;
    end else if (wr_hit_s) begin
      regs_r[PicoAddr[5:2]] <= PicoDataIn;
    end
  end

  // Read decode: scoring registers, STATUS, everything else reads as zero.
  always_comb begin
    rd_mux_s = 32'h0;
    if ((PicoAddr[1:0] == 2'b00) && (PicoAddr < 32'(NUM_REGS * 4))) begin
      rd_mux_s = regs_r[PicoAddr[5:2]];
    end else if (PicoAddr == STATUS_ADDR) begin
      rd_mux_s = {16'h0, 8'(count_r), 7'h0, (state_r == ISSUE)};
    end else begin
      rd_mux_s = 32'h0;
    end
  end

  // Read data is captured on a read strobe and held until the next one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      rdata_r <= 32'h0;
    else if (PicoRd) rdata_r <= rd_mux_s;
  end

  // Deframer next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      HDR:     if (si_xfer_s) state_next_s = QUERY; else state_next_s = HDR;
      QUERY:   if (si_xfer_s) state_next_s = ISSUE; else state_next_s = QUERY;
      ISSUE:   if (job_ready) state_next_s = HDR;   else state_next_s = ISSUE;
      default: state_next_s = HDR;
    endcase
  end

  // Deframer state plus registered inbound-ready (low in reset and in ISSUE).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= HDR;
      si_rdy_r <= 1'b0;
    end else begin
      state_r  <= state_next_s;
      si_rdy_r <= (state_next_s != ISSUE);
    end
  end

  // Latch header fields and the query beat as they arrive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_r        <= 16'h0;
      ref_addr_r  <= 32'h0;
      query_len_r <= 32'h0;
      ref_len_r   <= 32'h0;
      query_r     <= 128'h0;
    end else if (si_xfer_s && (state_r == HDR)) begin
      id_r        <= si_data[15:0];
      ref_addr_r  <= si_data[63:32];
      query_len_r <= si_data[95:64];
      ref_len_r   <= si_data[127:96];
    end else if (si_xfer_s && (state_r == QUERY)) begin
      query_r     <= si_data;
    end
  end

  // Occupancy after this cycle's push/pop.
  always_comb begin
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 1'b1;
      2'b01:   count_next_s = count_r - 1'b1;
      default: count_next_s = count_r;
    endcase
  end

  // Result FIFO pointers, occupancy and registered not-full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r      <= '0;
      rptr_r      <= '0;
      count_r     <= '0;
      res_ready_r <= 1'b0;
    end else begin
      if (push_s) wptr_r <= wptr_r + 1'b1;
      if (pop_s)  rptr_r <= rptr_r + 1'b1;
      count_r     <= count_next_s;
      res_ready_r <= (count_next_s != (AW + 1)'(OUT_FIFO_DEPTH));
    end
  end

  // Result FIFO storage; each entry is a packed outbound beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OUT_FIFO_DEPTH; i++) mem_r[i] <= 128'h0;
    end else if (push_s) begin
      mem_r[wptr_r[AW-1:0]] <= {80'h0, res_query_id, res_loc};
    end
  end

  assign PicoDataOut   = rdata_r;
  assign si_rdy        = si_rdy_r;
  assign res_ready     = res_ready_r;
  assign so_valid      = (count_r != '0);
  assign so_data       = mem_r[rptr_r[AW-1:0]];
  assign job_valid     = (state_r == ISSUE);
  assign job_query     = query_r;
  assign job_id        = id_r;
  assign job_ref_addr  = ref_addr_r;
  assign job_query_len = query_len_r;
  assign job_ref_len   = ref_len_r;

endmodule

// File: tb/tb_pico_sim.sv
// Self-checking bench for pico_sim: register map, deframing, job
// backpressure, result packing through a scoreboard, FIFO full, reset.
module tb_pico_sim;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [31:0]  PicoAddr, PicoDataIn, PicoDataOut;
  logic         PicoWr, PicoRd;
  logic         si_valid, si_rdy, so_valid, so_rdy;
  logic [127:0] si_data, so_data, job_query;
  logic [383:0] score_params;
  logic         job_valid, job_ready, res_valid, res_ready;
  logic [15:0]  job_id, res_query_id;
  logic [31:0]  job_ref_addr, job_query_len, job_ref_len, res_loc;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] exp_q[$];

  pico_sim #(.OUT_FIFO_DEPTH(4), .NUM_REGS(12)) dut (
    .clk(clk), .rst_n(rst_n),
    .PicoAddr(PicoAddr), .PicoDataIn(PicoDataIn), .PicoWr(PicoWr),
    .PicoRd(PicoRd), .PicoDataOut(PicoDataOut),
    .si_valid(si_valid), .si_data(si_data), .si_rdy(si_rdy),
    .so_valid(so_valid), .so_data(so_data), .so_rdy(so_rdy),
    .score_params(score_params),
    .job_valid(job_valid), .job_ready(job_ready), .job_query(job_query),
    .job_id(job_id), .job_ref_addr(job_ref_addr),
    .job_query_len(job_query_len), .job_ref_len(job_ref_len),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_query_id(res_query_id), .res_loc(res_loc)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Outbound monitor: every beat popped must match the scoreboard head.
  always @(negedge clk) begin
    if (rst_n && so_valid && so_rdy) begin
      if (exp_q.size() == 0) begin
        check("unexpected_beat", so_data, 128'hx);
      end else begin
        check("so_data", so_data, exp_q.pop_front());
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pico_write(input logic [31:0] a, input logic [31:0] d);
    PicoAddr = a; PicoDataIn = d; PicoWr = 1'b1;
    step();
    PicoWr = 1'b0;
  endtask

  task automatic pico_read(input string tag, input logic [31:0] a, input logic [31:0] exp);
    PicoAddr = a; PicoRd = 1'b1;
    step();
    PicoRd = 1'b0;
    check(tag, {96'h0, PicoDataOut}, {96'h0, exp});
  endtask

  task automatic send_beat(input logic [127:0] d);
    int n = 0;
    si_valid = 1'b1; si_data = d;
    while (!si_rdy && n < 50) begin step(); n++; end
    if (!si_rdy) check("si_rdy_timeout", 128'h0, 128'h1);
    step();
    si_valid = 1'b0;
  endtask

  task automatic send_res(input logic [15:0] id, input logic [31:0] loc);
    int n = 0;
    res_valid = 1'b1; res_query_id = id; res_loc = loc;
    while (!res_ready && n < 50) begin step(); n++; end
    if (!res_ready) check("res_ready_timeout", 128'h0, 128'h1);
    else exp_q.push_back({80'h0, id, loc});
    step();
    res_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || so_valid) && n < 50) begin step(); n++; end
    check("drain_done", {127'h0, (exp_q.size() == 0 && !so_valid)}, 128'h1);
  endtask

  localparam logic [127:0] HDR1 = 128'h00000080_00000040_00000000_00000008;
  localparam logic [127:0] QRY1 = 128'hc8facaa7c280aa28a020aaaf89aae004;

  initial begin
    logic [127:0] held;
    rst_n = 1'b0; PicoAddr = 32'h0; PicoDataIn = 32'h0; PicoWr = 1'b0; PicoRd = 1'b0;
    si_valid = 1'b0; si_data = 128'h0; so_rdy = 1'b1; job_ready = 1'b0;
    res_valid = 1'b0; res_query_id = 16'h0; res_loc = 32'h0;
    #23;
    check("rst_PicoDataOut", {96'h0, PicoDataOut}, 128'h0);
    check("rst_flags", {124'h0, si_rdy, so_valid, job_valid, res_ready}, 128'h0);
    check("rst_params_lo", score_params[127:0], 128'h0);
    rst_n = 1'b1;
    step(); step();
    check("post_rst_rdy", {126'h0, si_rdy, res_ready}, 128'h3);

    // Register write/readback and boundary addresses.
    pico_write(32'h00, 32'h2);
    pico_write(32'h04, 32'hFFFFFFFE);
    pico_write(32'h28, 32'hFFFFFFFE);
    pico_write(32'h2C, 32'hFFFFFFFF);
    pico_read("rd_00", 32'h00, 32'h2);
    pico_read("rd_04", 32'h04, 32'hFFFFFFFE);
    pico_read("rd_28", 32'h28, 32'hFFFFFFFE);
    pico_read("rd_2C", 32'h2C, 32'hFFFFFFFF);
    check("params_reg0", {96'h0, score_params[31:0]}, 128'h2);
    check("params_reg11", {96'h0, score_params[383:352]}, {96'h0, 32'hFFFFFFFF});
    pico_write(32'h40, 32'h5);
    pico_read("rd_40", 32'h40, 32'h0);
    pico_write(32'h01, 32'h77);
    check("unaligned_ignored", {96'h0, score_params[31:0]}, 128'h2);
    step(); step();
    check("rd_hold", {96'h0, PicoDataOut}, 128'h0);

    // Packet deframe.
    send_beat(HDR1);
    check("after_hdr", {126'h0, job_valid, si_rdy}, 128'h1);
    send_beat(QRY1);
    check("issue_flags", {126'h0, job_valid, si_rdy}, 128'h2);
    check("job_id", {112'h0, job_id}, 128'h8);
    check("job_ref_addr", {96'h0, job_ref_addr}, 128'h0);
    check("job_query_len", {96'h0, job_query_len}, 128'h40);
    check("job_ref_len", {96'h0, job_ref_len}, 128'h80);
    check("job_query", job_query, QRY1);

    // Job backpressure: offer a header meanwhile, it must not be taken.
    held = job_query;
    si_valid = 1'b1; si_data = HDR1;
    for (int i = 0; i < 10; i++) begin
      step();
      check("bp_stable", job_query, held);
      check("bp_flags", {126'h0, job_valid, si_rdy}, 128'h2);
    end
    si_valid = 1'b0;
    pico_read("status_pending", 32'h30, 32'h1);
    job_ready = 1'b1;
    step();
    job_ready = 1'b0;
    check("back_to_hdr", {126'h0, job_valid, si_rdy}, 128'h1);

    // Result formatting, in order.
    send_res(16'h8, 32'h123);
    send_res(16'h8, 32'h200);
    drain();

    // FIFO full: four fill it, the fifth waits for space.
    so_rdy = 1'b0;
    for (int i = 0; i < 4; i++) send_res(16'(i + 1), 32'h1000 + 32'(i));
    check("full_res_ready", {127'h0, res_ready}, 128'h0);
    pico_read("status_full", 32'h30, 32'h0000_0400);
    so_rdy = 1'b1;
    send_res(16'h5, 32'h1004);
    drain();

    // Reset mid-packet with a result still queued.
    pico_write(32'h14, 32'h33);
    so_rdy = 1'b0;
    send_res(16'h9, 32'h99);
    send_beat(HDR1);
    rst_n = 1'b0;
    exp_q.delete();
    #2;
    check("midrst_flags", {125'h0, job_valid, so_valid, si_rdy}, 128'h0);
    check("midrst_params", {96'h0, score_params[191:160]}, 128'h0);
    step();
    rst_n = 1'b1;
    so_rdy = 1'b1;
    step();
    send_beat(128'h00000010_00000020_00001000_0000ABCD);
    check("fresh_not_issue", {127'h0, job_valid}, 128'h0);
    send_beat(~QRY1);
    check("fresh_job_id", {112'h0, job_id}, {112'h0, 16'hABCD});
    check("fresh_ref_addr", {96'h0, job_ref_addr}, {96'h0, 32'h1000});
    check("fresh_query", job_query, ~QRY1);
    pico_read("status_after_rst", 32'h30, 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pico_sim.md
Name: pico_sim

Overview:
- Host-side front end of the Smith-Waterman accelerator.
- Holds the scoring parameters written over PicoBus.
- Deframes inbound stream packets (one 128-bit header beat plus one 128-bit query beat) into a job for the alignment engine.
- Packs each engine result into a 128-bit outbound stream beat.

Parameters:
- OUT_FIFO_DEPTH, 4: result beats buffered toward the outbound stream (power of 2, ≥2).
- NUM_REGS, 12: scoring registers at byte addresses 0x00–0x2C.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous, active-low reset.
- PicoAddr  in  32  PicoBus byte address.
- PicoDataIn  in  32  write data.
- PicoWr  in  1  write strobe, one cycle.
- PicoRd  in  1  read strobe, one cycle.
- PicoDataOut  out  32  read data, valid one cycle after PicoRd.
- si_valid  in  1  inbound stream beat valid.
- si_data  in  128  inbound beat.
- si_rdy  out  1  inbound accept.
- so_valid  out  1  outbound beat valid.
- so_data  out  128  outbound beat.
- so_rdy  in  1  outbound accept.
- score_params  out  384  the 12 registers; reg k occupies bits [32k+31:32k].
- job_valid  out  1  job offer to engine.
- job_ready  in  1  engine accepts job.
- job_query  out  128  query bases, 2 bits per base.
- job_id  out  16  query id.
- job_ref_addr  out  32  reference start byte address in DRAM.
- job_query_len  out  32  query length in bases.
- job_ref_len  out  32  reference length field.
- res_valid  in  1  engine result valid.
- res_ready  out  1  result accepted.
- res_query_id  in  16  query id of result.
- res_loc  in  32  alignment location.

Behaviour:
- Reset: all registers 0, PicoDataOut 0, si_rdy 0, so_valid 0, job_valid 0, res_ready 0, FSM in HDR, FIFO empty.
- Register map, word-aligned:
  - 0x00 AA, 0x04 AC, 0x08 AG, 0x0C AT, 0x10 CC, 0x14 CG, 0x18 CT, 0x1C GG, 0x20 GT, 0x24 TT, 0x28 GAP_OPEN, 0x2C GAP_EXTEND.
  - All values are signed 32-bit two's complement, stored verbatim.
  - 0x30 STATUS, read-only: bit0 = job pending (FSM in ISSUE), bits[15:8] = FIFO occupancy.
- PicoBus writes take effect on the next edge. Writes to addresses >0x2C or unaligned addresses are ignored.
- PicoBus reads: PicoDataOut is registered with 1-cycle latency and holds its value until the next read. Undefined addresses return 0.
- Header beat fields:
  - [15:0] query id.
  - [31:16] ignored.
  - [63:32] ref start address.
  - [95:64] query length.
  - [127:96] ref length.
- Input FSM:
  - HDR: si_rdy=1. On si_valid, latch header and go to QUERY.
  - QUERY: si_rdy=1. On si_valid, latch query beat and go to ISSUE.
  - ISSUE: si_rdy=0, job_valid=1, job outputs stable. On job_ready, go to HDR on the next edge.
- A beat transfers only when si_valid && si_rdy are both high at a rising edge.
- Result path:
  - res_ready = FIFO not full. A result transfers when res_valid && res_ready.
  - Pushed beat = {80'b0, res_query_id, res_loc}.
  - so_valid = FIFO not empty; so_data = head entry, driven combinationally from FIFO storage.
  - Pop on so_valid && so_rdy.
  - Simultaneous push and pop when full or empty are both legal; occupancy is unchanged when both occur.
- Every engine result is forwarded in arrival order, with no merging or filtering.
- Input and result paths are independent: a new header is accepted while results are still draining.
- rst_n asserted mid-packet or mid-FIFO discards all state. The scoring registers return to 0.

Test Plan:
- Register write/readback:
  - Write 0x00=2, 0x04=0xFFFFFFFE, 0x28=0xFFFFFFFE, 0x2C=0xFFFFFFFF.
  - Read back those exact values one cycle after PicoRd.
  - score_params[31:0]=2, score_params[383:352]=0xFFFFFFFF.
  - Write 0x40=5, then read 0x40 → 0.
- Packet deframe:
  - Send header 0x00000080_00000040_00000000_00000008, then query beat 0xc8facaa7c280aa28a020aaaf89aae004.
  - Expect job_valid with job_id=8, job_ref_addr=0, job_query_len=0x40, job_ref_len=0x80, job_query=that beat.
  - si_rdy=0 until job_ready.
- Job backpressure: hold job_ready=0 for 10 cycles → job outputs stable, si_rdy=0, STATUS bit0=1. Raise job_ready → next cycle in HDR, si_rdy=1.
- Result formatting:
  - Engine returns (id 8, loc 0x123) then (id 8, loc 0x200).
  - Two outbound beats in order; beat[47:32]=8, beat[31:0]=0x123 then 0x200; upper 80 bits 0.
- FIFO full: hold so_rdy=0 and push 5 results → res_ready drops after 4. Release so_rdy → all 5 emerge in order with no loss.
- Reset mid-packet: assert rst_n low after the header beat → job_valid=0, FIFO empty, registers 0. After release, a fresh header is accepted as a header.
